// File: rtl/shiftright_pkg.sv
// rtl/shiftright_pkg.sv - register map, widths and lane arithmetic for the shiftright core
package shiftright_pkg;

    localparam int SHIFT_W           = 4;
    localparam int MAX_SHIFT_DEFAULT = 15;
    localparam int ITEM_W            = 32;
    localparam int ADDR_W            = 20;

    localparam logic [ADDR_W-1:0] REG_SHIFT     = 20'h00000;
    localparam logic [ADDR_W-1:0] REG_PKT_COUNT = 20'h00004;
    localparam logic [ADDR_W-1:0] REG_ITEM_W    = 20'h00008;

    typedef struct packed {
        logic signed [16:0] sum_i;
        logic signed [16:0] sum_q;
        logic [SHIFT_W-1:0] shift;
        logic               keep;
        logic               last;
    } s1_t;

    // Adding half an LSB of the result before the arithmetic shift gives round-half-up.
    function automatic logic signed [16:0] round_sum(input logic [15:0] x,
                                                     input logic [SHIFT_W-1:0] s);
        logic [16:0] half;
        half = (17'd1 << s) >> 1;
        return $signed({x[15], x}) + $signed(half);
    endfunction

    function automatic logic [15:0] shift_lane(input logic signed [16:0] sum,
                                               input logic [SHIFT_W-1:0] s);
        logic signed [16:0] t;
        t = sum >>> s;
        return t[15:0];
    endfunction

endpackage

// File: rtl/shiftright_regs.sv
// rtl/shiftright_regs.sv - ctrlport responder holding SHIFT and PKT_COUNT
module shiftright_regs
    import shiftright_pkg::*;
#(
    parameter int MAX_SHIFT = MAX_SHIFT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_wr,
    input  logic               req_rd,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_data,
    output logic               resp_ack,
    output logic [31:0]        resp_data,
    input  logic               pkt_done,
    output logic [SHIFT_W-1:0] shift
);

    logic               ack_q, ack_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [31:0]        pkt_count_q, pkt_count_d;

    always_comb begin
        ack_d       = 1'b0;
        resp_data_d = '0;
        shift_d     = shift_q;
        pkt_count_d = pkt_count_q;
        if (pkt_done) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        // A write takes priority over a read; its clear overrides the increment above.
        if (req_wr) begin
            ack_d = 1'b1;
            case (req_addr)
                REG_SHIFT: begin
                    shift_d = (req_data > 32'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT)
                                                          : req_data[SHIFT_W-1:0];
                end
                REG_PKT_COUNT: pkt_count_d = '0;
                default: ;
            endcase
        end else if (req_rd) begin
            ack_d = 1'b1;
            case (req_addr)
                REG_SHIFT:     resp_data_d = 32'(shift_q);
                REG_PKT_COUNT: resp_data_d = pkt_count_q;
                REG_ITEM_W:    resp_data_d = 32'(ITEM_W);
                default:       resp_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q       <= 1'b0;
            resp_data_q <= '0;
            shift_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            ack_q       <= ack_d;
            resp_data_q <= resp_data_d;
            shift_q     <= shift_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign resp_ack  = ack_q;
    assign resp_data = resp_data_q;
    assign shift     = shift_q;

endmodule

// File: rtl/shiftright_core.sv
// rtl/shiftright_core.sv - sc16 rounding right-shift user core with context passthrough
module shiftright_core
    import shiftright_pkg::*;
#(
    parameter int CHDR_W    = 64,
    parameter int MAX_SHIFT = MAX_SHIFT_DEFAULT
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data,
    input  logic [31:0]       s_in_payload_tdata,
    input  logic              s_in_payload_tkeep,
    input  logic              s_in_payload_tlast,
    input  logic              s_in_payload_tvalid,
    output logic              s_in_payload_tready,
    input  logic [CHDR_W-1:0] s_in_context_tdata,
    input  logic [3:0]        s_in_context_tuser,
    input  logic              s_in_context_tlast,
    input  logic              s_in_context_tvalid,
    output logic              s_in_context_tready,
    output logic [31:0]       m_out_payload_tdata,
    output logic              m_out_payload_tkeep,
    output logic              m_out_payload_tlast,
    output logic              m_out_payload_tvalid,
    input  logic              m_out_payload_tready,
    output logic [CHDR_W-1:0] m_out_context_tdata,
    output logic [3:0]        m_out_context_tuser,
    output logic              m_out_context_tlast,
    output logic              m_out_context_tvalid,
    input  logic              m_out_context_tready
);

    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] eff_shift;
    logic               pkt_done;
    logic               s2_advance;
    logic               in_fire;
    logic               ctx_ready;

    s1_t                s1_q, s1_d;
    logic               s1_valid_q, s1_valid_d;
    logic [31:0]        s2_data_q, s2_data_d;
    logic               s2_keep_q, s2_keep_d;
    logic               s2_last_q, s2_last_d;
    logic               s2_valid_q, s2_valid_d;
    logic               sop_q, sop_d;
    logic [SHIFT_W-1:0] shift_active_q, shift_active_d;
    logic [CHDR_W-1:0]  ctx_data_q, ctx_data_d;
    logic [3:0]         ctx_user_q, ctx_user_d;
    logic               ctx_last_q, ctx_last_d;
    logic               ctx_valid_q, ctx_valid_d;

    shiftright_regs #(
        .MAX_SHIFT (MAX_SHIFT)
    ) u_regs (
        .clk       (ce_clk),
        .rst       (ce_rst),
        .req_wr    (s_ctrlport_req_wr),
        .req_rd    (s_ctrlport_req_rd),
        .req_addr  (s_ctrlport_req_addr),
        .req_data  (s_ctrlport_req_data),
        .resp_ack  (s_ctrlport_resp_ack),
        .resp_data (s_ctrlport_resp_data),
        .pkt_done  (pkt_done),
        .shift     (shift_reg)
    );

    assign s2_advance          = !s2_valid_q || m_out_payload_tready;
    assign s_in_payload_tready = !s1_valid_q || s2_advance;
    assign in_fire             = s_in_payload_tvalid && s_in_payload_tready;
    // The first beat of a packet uses the live register; later beats reuse the latched value.
    assign eff_shift           = sop_q ? shift_reg : shift_active_q;
    assign ctx_ready           = !ctx_valid_q || m_out_context_tready;
    assign s_in_context_tready = ctx_ready;
    assign pkt_done            = s2_valid_q && m_out_payload_tready && s2_last_q;

    always_comb begin
        s1_d           = s1_q;
        s1_valid_d     = s1_valid_q;
        s2_data_d      = s2_data_q;
        s2_keep_d      = s2_keep_q;
        s2_last_d      = s2_last_q;
        s2_valid_d     = s2_valid_q;
        sop_d          = sop_q;
        shift_active_d = shift_active_q;
        ctx_data_d     = ctx_data_q;
        ctx_user_d     = ctx_user_q;
        ctx_last_d     = ctx_last_q;
        ctx_valid_d    = ctx_valid_q;

        if (s_in_payload_tready) begin
            s1_valid_d = s_in_payload_tvalid;
            if (in_fire) begin
                s1_d.sum_i = round_sum(s_in_payload_tdata[31:16], eff_shift);
                s1_d.sum_q = round_sum(s_in_payload_tdata[15:0], eff_shift);
                s1_d.shift = eff_shift;
                s1_d.keep  = s_in_payload_tkeep;
                s1_d.last  = s_in_payload_tlast;
                sop_d      = s_in_payload_tlast;
                if (sop_q) begin
                    shift_active_d = shift_reg;
                end
            end
        end

        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = {shift_lane(s1_q.sum_i, s1_q.shift),
                             shift_lane(s1_q.sum_q, s1_q.shift)};
                s2_keep_d = s1_q.keep;
                s2_last_d = s1_q.last;
            end
        end

        if (ctx_ready) begin
            ctx_valid_d = s_in_context_tvalid;
            if (s_in_context_tvalid) begin
                ctx_data_d = s_in_context_tdata;
                ctx_user_d = s_in_context_tuser;
                ctx_last_d = s_in_context_tlast;
            end
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            s1_q           <= '0;
            s1_valid_q     <= 1'b0;
            s2_data_q      <= '0;
            s2_keep_q      <= 1'b0;
            s2_last_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            sop_q          <= 1'b1;
            shift_active_q <= '0;
            ctx_data_q     <= '0;
            ctx_user_q     <= '0;
            ctx_last_q     <= 1'b0;
            ctx_valid_q    <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s1_valid_q     <= s1_valid_d;
            s2_data_q      <= s2_data_d;
            s2_keep_q      <= s2_keep_d;
            s2_last_q      <= s2_last_d;
            s2_valid_q     <= s2_valid_d;
            sop_q          <= sop_d;
            shift_active_q <= shift_active_d;
            ctx_data_q     <= ctx_data_d;
            ctx_user_q     <= ctx_user_d;
            ctx_last_q     <= ctx_last_d;
            ctx_valid_q    <= ctx_valid_d;
        end
    end

    assign m_out_payload_tdata  = s2_data_q;
    assign m_out_payload_tkeep  = s2_keep_q;
    assign m_out_payload_tlast  = s2_last_q;
    assign m_out_payload_tvalid = s2_valid_q;
    assign m_out_context_tdata  = ctx_data_q;
    assign m_out_context_tuser  = ctx_user_q;
    assign m_out_context_tlast  = ctx_last_q;
    assign m_out_context_tvalid = ctx_valid_q;

endmodule

// File: doc/shiftright_core.md
# shiftright_core

User-logic core for the shiftright RFNoC block; it is the receiving and answering end of the shiftright NoC shell's client interface. It responds to CtrlPort requests from the shell's ctrlport endpoint and consumes the shell's input payload/context streams. Each sc16 sample is arithmetically right-shifted with round-half-up, and the results are returned on the output payload/context streams for CHDR framing. It runs entirely in the shell's ce_clk domain.

## Interface
- CHDR_W, 64: context bus width; must match the shell.
- MAX_SHIFT, 15: largest accepted shift value; written values above this are clamped.
- ce_clk  in  1  core clock, shared by ctrlport and axis data.
- ce_rst  in  1  asynchronous, active-high reset.
- s_ctrlport_req_wr / s_ctrlport_req_rd  in  1  single-cycle request strobes.
- s_ctrlport_req_addr  in  20  byte address.
- s_ctrlport_req_data  in  32  write data.
- s_ctrlport_resp_ack  out  1  one-cycle response strobe.
- s_ctrlport_resp_data  out  32  read data; 0 on writes.
- s_in_payload_tdata/tkeep/tlast/tvalid  in  32/1/1/1  input samples: I in [31:16], Q in [15:0].
- s_in_payload_tready  out  1  payload input ready.
- s_in_context_tdata/tuser/tlast/tvalid  in  CHDR_W/4/1/1  input context.
- s_in_context_tready  out  1  context input ready.
- m_out_payload_tdata/tkeep/tlast/tvalid  out  32/1/1/1  output samples.
- m_out_payload_tready  in  1  payload output ready.
- m_out_context_tdata/tuser/tlast/tvalid  out  CHDR_W/4/1/1  output context.
- m_out_context_tready  in  1  context output ready.

## Operation
- Register map, exact 20-bit address decode:
  - 0x00 SHIFT: rw, bits [3:0]; bits [31:4] read 0.
  - 0x04 PKT_COUNT: ro count of output payload packets (tlast handshakes on m_out_payload). A write of any value clears it.
  - 0x08 ITEM_W: ro constant 32.
- Every request gets exactly one ack, including unmapped addresses. An unmapped read returns 0; an unmapped write has no effect. A request with wr and rd both set is treated as a write.
- Shift latching: shift_active loads from SHIFT on the first accepted beat of each packet. Start-of-packet is set at reset and after each accepted tlast beat. A SHIFT write mid-packet affects only the next packet.
- Arithmetic, per 16-bit lane x and shift s:
  - s=0: y = x.
  - s>0: y = (sext17(x) + 2^(s-1)) >>> s, truncated to 16 bits.
  - The result always fits 16 bits, so no saturation. Example: 32767, s=1 gives 16384.
- tkeep and tlast travel with their data unchanged.
- Context passes through unmodified with one register stage. The packet length is unchanged because output item count equals input item count. Context and payload are independent handshakes; there is no cross-coupling.
- PKT_COUNT wraps 0xFFFFFFFF to 0. If a clear and an increment occur in the same cycle, the clear wins.

## Timing
- Reset values: all tvalid 0, s_ctrlport_resp_ack 0, resp_data 0, SHIFT 0, shift_active 0, PKT_COUNT 0, start-of-packet 1. Both tready outputs are 1 once reset is released.
- CtrlPort: ack and data are asserted exactly 1 cycle after the request strobe, for 1 cycle. Back-to-back requests on consecutive cycles are supported. A SHIFT write is visible to a read issued the next cycle.
- Payload is a 2-stage stallable pipeline:
  - Stage 1 computes the rounded sum; stage 2 shifts and registers the output.
  - Latency is 2 cycles from the input handshake to m_out tvalid.
  - Throughput is 1 beat/cycle while m_out_payload_tready=1.
  - A stage advances when it is empty or the stage downstream of it is accepting.
  - s_in_payload_tready = !s1_valid || s1_advance, and is combinational only from internal state and m_out_payload_tready.
- Context is a 1-stage skid register: latency 1 cycle, full throughput.
- Output tdata/tuser/tlast hold stable while tvalid=1 and tready=0.
- Reset asserted mid-packet flushes both pipelines immediately; partial packets are discarded and the shell's flush logic handles the framing.

## Structure
- shiftright_pkg holds register addresses, SHIFT_W=4, MAX_SHIFT default and ITEM_W.
- shiftright_regs is one sub-module: the ctrlport responder plus SHIFT and PKT_COUNT.
- The round/shift datapath, payload pipeline and context stage are in the top module.

## Test plan
- Write 0x00=2, then read 0x00 -> ack 1 cycle after each request; read data 2. Read 0x1FC -> data 0, ack present. Write SHIFT=31 -> reads back 15.
- SHIFT=4, stream I=0x0018 (24), Q=0xFFE8 (-24) -> I=2 (24+8=32, >>4), Q=-1 (0xFFFF). Output appears 2 cycles after input, continuous throughput.
- SHIFT=0, 8-beat packet of random data -> bit-exact passthrough with tlast on beat 8; PKT_COUNT reads 1.
- Write SHIFT from 1 to 3 during beat 4 of a 10-beat packet -> whole packet shifted by 1; next packet shifted by 3.
- Random m_out_payload_tready and m_out_context_tready (50% duty), 100 packets -> no loss, duplication or reorder; output stable under stall; PKT_COUNT=100.
- Clear PKT_COUNT in the same cycle as an output tlast handshake -> reads 0. Assert ce_rst mid-packet -> all tvalid 0 on the next edge and SHIFT reads 0.
